// File: rtl/prio_irq_ctrl.sv
// Registered priority interrupt controller: latches request events into a pending register and
// presents the highest-priority enabled pending line as an index, retired by ack.
module prio_irq_ctrl #(
    parameter int unsigned  N         = 8,
    parameter bit           EDGE      = 1'b1,
    parameter bit           MSB_FIRST = 1'b1,
    localparam int unsigned W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] en,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] id,
    output logic [N-1:0] pend,
    output logic         lost
);

    logic [N-1:0] req_q;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] sel;
    logic         valid_q, valid_d;
    logic [W-1:0] id_q, id_d;
    logic         lost_q, lost_d;

    // ack only retires the id that is currently being presented.
    always_comb begin
        clr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            clr[i] = ack && valid_q && (id_q == W'(i));
        end
    end

    always_comb begin
        rise    = EDGE ? (req & ~req_q) : '0;
        // Set wins over clear so a fresh event on the retiring line is kept.
        pend_d  = EDGE ? ((pend_q & ~clr) | rise) : req;
        lost_d  = EDGE ? (lost_q | (|(rise & pend_q & ~clr))) : 1'b0;
        sel     = pend_d & en;
        valid_d = |sel;
    end

    always_comb begin
        id_d = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel[i]) begin
                    id_d = W'(i);
                end
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (sel[i]) begin
                    id_d = W'(i);
                end
            end
        end
    end

    // req_q loads during reset too, so a line held high through reset gives no edge afterwards.
    always_ff @(posedge clk) begin
        req_q <= req;
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            lost_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            lost_q  <= lost_d;
        end
    end

    assign valid = valid_q;
    assign id    = id_q;
    assign pend  = pend_q;
    assign lost  = lost_q;

endmodule
